// File: rtl/m8088_bus_responder.sv
// 8088 local-bus slave: turns CPU read/write/INTA bus cycles into single backend requests.
// Define M8088_RESP_TIMEOUT_EN to abandon a backend request after 1023 cycles without ack.
module m8088_bus_responder #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        CORE_CLK,
    input  logic        RESET,
    input  logic [19:0] addr,
    input  logic [7:0]  dout,
    input  logic        ALE,
    input  logic        RD_n,
    input  logic        WR_n,
    input  logic        IOM,
    input  logic        INTA_n,
    output logic [7:0]  din,
    output logic        READY,
    output logic        req,
    output logic        req_we,
    output logic        req_io,
    output logic [19:0] req_addr,
    output logic [7:0]  req_wdata,
    input  logic        ack,
    input  logic [7:0]  rdata,
    input  logic [7:0]  irq_vector,
    output logic        inta_done,
    output logic        timeout_err
);

    typedef enum logic [2:0] {StIdle, StAddr, StReq, StWait, StHold} state_e;

    localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

    state_e     state_q;
    logic [3:0] wait_cnt_q;
    logic       inta_phase_q;
    logic       discard_q;
    logic       rw_idle;
`ifdef M8088_RESP_TIMEOUT_EN
    logic [9:0] tmo_cnt_q;
`endif

    assign rw_idle = RD_n & WR_n;

    always_ff @(posedge CORE_CLK) begin
        inta_done <= 1'b0;
`ifdef M8088_RESP_TIMEOUT_EN
        timeout_err <= 1'b0;
`endif
        if (RESET) begin
            state_q      <= StIdle;
            READY        <= 1'b1;
            din          <= 8'hFF;
            req          <= 1'b0;
            req_we       <= 1'b0;
            req_io       <= 1'b0;
            req_addr     <= 20'h0;
            req_wdata    <= 8'h0;
            inta_phase_q <= 1'b0;
            discard_q    <= 1'b0;
            wait_cnt_q   <= 4'h0;
`ifdef M8088_RESP_TIMEOUT_EN
            tmo_cnt_q    <= 10'h0;
`endif
        end else if (ALE) begin
            // A new address phase abandons whatever cycle was in progress.
            state_q   <= StAddr;
            req_addr  <= addr;
            req_io    <= ~IOM;
            req       <= 1'b0;
            READY     <= 1'b1;
            discard_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StAddr: begin
                    if (!WR_n) begin
                        req       <= 1'b1;
                        req_we    <= 1'b1;
                        req_wdata <= dout;
                        READY     <= 1'b0;
                        discard_q <= 1'b0;
                        state_q   <= StReq;
`ifdef M8088_RESP_TIMEOUT_EN
                        tmo_cnt_q <= 10'h0;
`endif
                    end else if (!RD_n) begin
                        req       <= 1'b1;
                        req_we    <= 1'b0;
                        READY     <= 1'b0;
                        discard_q <= 1'b0;
                        state_q   <= StReq;
`ifdef M8088_RESP_TIMEOUT_EN
                        tmo_cnt_q <= 10'h0;
`endif
                    end else if (!INTA_n) begin
                        // First INTA pulse is a dummy; the second carries the vector.
                        inta_phase_q <= ~inta_phase_q;
                        READY        <= 1'b1;
                        state_q      <= StHold;
                        if (inta_phase_q) begin
                            din       <= irq_vector;
                            inta_done <= 1'b1;
                        end else begin
                            din <= 8'hFF;
                        end
                    end
                end
                StReq: begin
                    if (ack) begin
                        req <= 1'b0;
                        if (discard_q || rw_idle) begin
                            // CPU already left the cycle: drop the result.
                            READY   <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            if (!req_we) din <= rdata;
                            wait_cnt_q <= WaitLoad;
                            if (WAIT_STATES == 0) begin
                                READY   <= 1'b1;
                                state_q <= StHold;
                            end else begin
                                state_q <= StWait;
                            end
                        end
                    end else begin
                        if (rw_idle) discard_q <= 1'b1;
`ifdef M8088_RESP_TIMEOUT_EN
                        if (tmo_cnt_q == 10'd1022) begin
                            req         <= 1'b0;
                            din         <= 8'hFF;
                            READY       <= 1'b1;
                            timeout_err <= 1'b1;
                            state_q     <= StHold;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + 10'd1;
                        end
`endif
                    end
                end
                StWait: begin
                    wait_cnt_q <= wait_cnt_q - 4'd1;
                    if (wait_cnt_q == 4'd1) begin
                        READY   <= 1'b1;
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    if (rw_idle && INTA_n) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifndef M8088_RESP_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_m8088_bus_responder.sv
// Self-checking bench for m8088_bus_responder: vector table, random bus cycles, corner sequences.
`timescale 1ns/1ps
module tb_m8088_bus_responder;

    localparam int unsigned WS = 1;

    logic        CORE_CLK = 1'b0;
    logic        RESET;
    logic [19:0] addr;
    logic [7:0]  dout;
    logic        ALE, RD_n, WR_n, IOM, INTA_n;
    logic [7:0]  din;
    logic        READY;
    logic        req, req_we, req_io;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        ack;
    logic [7:0]  rdata;
    logic [7:0]  irq_vector;
    logic        inta_done;
    logic        timeout_err;

    always #5 CORE_CLK = ~CORE_CLK;

    m8088_bus_responder #(.WAIT_STATES(WS)) dut (
        .CORE_CLK   (CORE_CLK),
        .RESET      (RESET),
        .addr       (addr),
        .dout       (dout),
        .ALE        (ALE),
        .RD_n       (RD_n),
        .WR_n       (WR_n),
        .IOM        (IOM),
        .INTA_n     (INTA_n),
        .din        (din),
        .READY      (READY),
        .req        (req),
        .req_we     (req_we),
        .req_io     (req_io),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ack        (ack),
        .rdata      (rdata),
        .irq_vector (irq_vector),
        .inta_done  (inta_done),
        .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;

    // Event counters sampled mid-cycle; tests take deltas across a transaction.
    int   req_rises   = 0;
    int   inta_pulses = 0;
    int   tmo_pulses  = 0;
    logic req_prev    = 1'b0;
    always @(negedge CORE_CLK) begin
        if (req === 1'b1 && req_prev !== 1'b1) req_rises++;
        if (inta_done === 1'b1) inta_pulses++;
        if (timeout_err === 1'b1) tmo_pulses++;
        req_prev = req;
    end

    // Reference model state: what the CPU should see on din, and the INTA phase.
    logic [7:0] m_din;
    bit         m_phase;

    typedef struct {
        int          kind;   // 0 read, 1 write, 2 write with RD_n also low, 3 INTA (vector in wd)
        logic [19:0] a;
        bit          iom;
        logic [7:0]  wd;
        logic [7:0]  rd;
        int          delay;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge CORE_CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (3) tick();
        RESET = 1'b0;
        m_din   = 8'hFF;
        m_phase = 1'b0;
    endtask

    task automatic bus_cycle(input int kind, input logic [19:0] a, input bit iom,
                             input logic [7:0] wd, input logic [7:0] rd, input int delay);
        int r0;
        bit is_wr;
        r0    = req_rises;
        is_wr = (kind != 0);
        ALE = 1'b1; addr = a; IOM = iom;
        tick();
        ALE = 1'b0; addr = 20'($urandom);
        check("ale_addr", req_addr, a);
        check("ale_io", req_io, !iom);
        check("ale_noreq", req, 1'b0);
        dout = wd; WR_n = !is_wr; RD_n = (kind == 1);
        tick();
        dout = 8'($urandom);
        check("strobe_req", req, 1'b1);
        check("strobe_we", req_we, is_wr);
        check("strobe_ready", READY, 1'b0);
        if (is_wr) check("wdata", req_wdata, wd);
        for (int i = 0; i < delay; i++) begin
            tick();
            check("req_held", req, 1'b1);
            check("ready_low", READY, 1'b0);
        end
        ack = 1'b1; rdata = rd;
        tick();
        ack = 1'b0; rdata = 8'($urandom);
        if (!is_wr) m_din = rd;
        check("ack_req_drop", req, 1'b0);
        check("ack_din", din, m_din);
        for (int k = 0; k < int'(WS); k++) begin
            check("wait_ready", READY, 1'b0);
            tick();
        end
        check("ready_up", READY, 1'b1);
        RD_n = 1'b1; WR_n = 1'b1;
        tick();
        tick();
        check("end_ready", READY, 1'b1);
        check("end_din", din, m_din);
        check("one_req", req_rises - r0, 1);
    endtask

    task automatic inta_cycle(input logic [7:0] vec);
        int r0, p0;
        bit ph;
        r0 = req_rises;
        p0 = inta_pulses;
        ph = m_phase;
        ALE = 1'b1; addr = 20'($urandom); IOM = 1'b0;
        tick();
        ALE = 1'b0;
        irq_vector = vec; INTA_n = 1'b0;
        tick();
        m_din   = ph ? vec : 8'hFF;
        m_phase = !ph;
        check("inta_din", din, m_din);
        check("inta_ready", READY, 1'b1);
        check("inta_done", inta_done, ph);
        INTA_n = 1'b1; irq_vector = 8'($urandom);
        tick();
        tick();
        check("inta_din_held", din, m_din);
        check("inta_pulses", inta_pulses - p0, ph);
        check("inta_noreq", req_rises - r0, 0);
    endtask

    task automatic run_vec(input vec_t v);
        if (v.kind == 3) inta_cycle(v.wd);
        else bus_cycle(v.kind, v.a, v.iom, v.wd, v.rd, v.delay);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0, t0, n;
        vec_t v;
        RESET = 1'b1; ALE = 1'b0; RD_n = 1'b1; WR_n = 1'b1; INTA_n = 1'b1; IOM = 1'b0;
        addr = 20'h0; dout = 8'h0; ack = 1'b0; rdata = 8'h0; irq_vector = 8'h0;
        do_reset();
        check("rst_ready", READY, 1'b1);
        check("rst_din", din, 8'hFF);
        check("rst_req", req, 1'b0);
        check("rst_we", req_we, 1'b0);
        check("rst_io", req_io, 1'b0);
        check("rst_addr", req_addr, 20'h0);
        check("rst_wdata", req_wdata, 8'h0);
        check("rst_inta_done", inta_done, 1'b0);
        check("rst_tmo", timeout_err, 1'b0);

        vecs[0] = '{0, 20'hF0010, 1'b1, 8'h00, 8'h5A, 2};
        vecs[1] = '{1, 20'h00040, 1'b0, 8'hC3, 8'h00, 1};
        vecs[2] = '{3, 20'h00000, 1'b0, 8'h21, 8'h00, 0};
        vecs[3] = '{3, 20'h00000, 1'b0, 8'h21, 8'h00, 0};
        vecs[4] = '{2, 20'h12345, 1'b1, 8'h96, 8'h11, 0};
        vecs[5] = '{0, 20'hFFFFF, 1'b0, 8'h00, 8'hA5, 0};
        vecs[6] = '{0, 20'h00000, 1'b1, 8'h00, 8'h3C, 4};
        vecs[7] = '{1, 20'h80001, 1'b1, 8'hFF, 8'h00, 3};
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        for (int i = 0; i < 30; i++) begin
            v.kind  = int'($urandom_range(0, 3));
            v.a     = 20'($urandom);
            v.iom   = 1'($urandom);
            v.wd    = 8'($urandom);
            v.rd    = 8'($urandom);
            v.delay = int'($urandom_range(0, 5));
            run_vec(v);
        end

        // ALE while a request is pending: request withdrawn, new address taken.
        ALE = 1'b1; addr = 20'hABCDE; IOM = 1'b1;
        tick();
        ALE = 1'b0; RD_n = 1'b0;
        tick();
        check("abort_pre_req", req, 1'b1);
        RD_n = 1'b1; ALE = 1'b1; addr = 20'h13579; IOM = 1'b0;
        tick();
        ALE = 1'b0;
        check("abort_req", req, 1'b0);
        check("abort_addr", req_addr, 20'h13579);
        check("abort_io", req_io, 1'b1);
        WR_n = 1'b0; dout = 8'h5E;
        tick();
        check("abort_new_we", req_we, 1'b1);
        check("abort_new_wdata", req_wdata, 8'h5E);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        repeat (WS) tick();
        check("abort_ready", READY, 1'b1);
        WR_n = 1'b1;
        tick();
        tick();

        // Strobe released before ack: request still completes, result is discarded.
        r0 = req_rises;
        ALE = 1'b1; addr = 20'h02222; IOM = 1'b1;
        tick();
        ALE = 1'b0; RD_n = 1'b0;
        tick();
        RD_n = 1'b1;
        tick();
        check("early_req_held", req, 1'b1);
        tick();
        check("early_req_held2", req, 1'b1);
        ack = 1'b1; rdata = 8'h77;
        tick();
        ack = 1'b0;
        check("early_req_drop", req, 1'b0);
        check("early_din_kept", din, m_din);
        check("early_ready", READY, 1'b1);
        tick();
        check("early_one_req", req_rises - r0, 1);

        // RESET during WAIT, with ALE asserted on the same edge.
        if (!m_phase) inta_cycle(8'h99);
        ALE = 1'b1; addr = 20'h03333; IOM = 1'b0;
        tick();
        ALE = 1'b0; RD_n = 1'b0;
        tick();
        ack = 1'b1; rdata = 8'h44;
        tick();
        ack = 1'b0;
        check("wait_ready_low", READY, 1'b0);
        RESET = 1'b1; ALE = 1'b1; addr = 20'hFFFFF;
        tick();
        check("mid_rst_ready", READY, 1'b1);
        check("mid_rst_din", din, 8'hFF);
        check("mid_rst_req", req, 1'b0);
        check("mid_rst_addr", req_addr, 20'h0);
        check("mid_rst_io", req_io, 1'b0);
        RESET = 1'b0; ALE = 1'b0; RD_n = 1'b1;
        m_din = 8'hFF; m_phase = 1'b0;
        tick();
        inta_cycle(8'h5C);

        // Backend never acks.
        t0 = tmo_pulses;
        n  = 0;
        ALE = 1'b1; addr = 20'h0BEEF; IOM = 1'b1;
        tick();
        ALE = 1'b0; RD_n = 1'b0;
        tick();
`ifdef M8088_RESP_TIMEOUT_EN
        for (int i = 1; i <= 1100; i++) begin
            tick();
            if (timeout_err === 1'b1) begin
                n = i;
                break;
            end
        end
        check("tmo_cycles", n, 1023);
        check("tmo_din", din, 8'hFF);
        check("tmo_ready", READY, 1'b1);
        check("tmo_req", req, 1'b0);
        m_din = 8'hFF;
        RD_n = 1'b1;
        tick();
        tick();
        check("tmo_one_pulse", tmo_pulses - t0, 1);
`else
        repeat (1100) tick();
        check("notmo_ready", READY, 1'b0);
        check("notmo_req", req, 1'b1);
        check("notmo_pulses", tmo_pulses - t0 + n, 0);
        ack = 1'b1; rdata = 8'h42;
        tick();
        ack = 1'b0;
        m_din = 8'h42;
        repeat (WS) tick();
        check("notmo_late_ready", READY, 1'b1);
        check("notmo_late_din", din, m_din);
        RD_n = 1'b1;
        tick();
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
